odometer_meas_ctrl: RTL and testbench
=====================================

ODOMETER_MEAS_CTRL -- requirements
Module: odometer_meas_ctrl

Interface
REQ-001 SHALL have parameter MEAS_CYCLES, default 256, MEAS_TRIG high-time in CLK cycles (range 1..65535).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, wait after MEAS_TRIG falls before BF_COUNT is sampled (range 1..255).
REQ-003 CLK  input  1  single clock; all logic rising-edge.
REQ-004 RESETB  input  1  reset, synchronous, active-low.
REQ-005 CFG_VALID / CFG_READY  input / output  1 / 1  campaign request handshake.
REQ-006 CFG_SEL  input  2  chain select: 00=INV97, 01=INV99, 10=INV101, 11=reserved (treated as 01).
REQ-007 CFG_AC_DC  input  1  stress mode forwarded to AC_DC.
REQ-008 CFG_STRESS_CYCLES  input  16  stress duration per iteration.
REQ-009 CFG_NUM_MEAS  input  4  measurement iterations; 0 treated as 1.
REQ-010 LOAD, SEL_INV97, SEL_INV99, SEL_INV101, START, AC_DC, MEAS_TRIG  output  1 each  drive odometer control inputs.
REQ-011 BF_COUNT  input  12  beat-frequency count returned by odometer.
REQ-012 RES_VALID / RES_READY  output / input  1 / 1  result handshake.
REQ-013 RES_DATA  output  12; RES_IDX  output  4  result value and iteration index (0-based).
REQ-014 BUSY  output  1  high in every state except IDLE; DONE  output  1  one-cycle pulse at campaign end.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, STRESS, MEAS, SETTLE, CAPTURE, WAIT_RD, FINISH.
REQ-016 IDLE: CFG_READY=1; on CFG_VALID&CFG_READY SHALL register all CFG_* fields, clear iteration counter, go LOAD.
REQ-017 LOAD: LOAD=1 for exactly one cycle with SEL_INV*, AC_DC, START=0 already stable; one-hot SEL_INV* held from LOAD until return to IDLE.
REQ-018 After LOAD, SHALL enter STRESS with START=1 for exactly CFG_STRESS_CYCLES cycles; if CFG_STRESS_CYCLES=0 SHALL go directly to MEAS (START stays 0).
REQ-019 MEAS: START=0, MEAS_TRIG=1 for exactly MEAS_CYCLES cycles.
REQ-020 SETTLE: MEAS_TRIG=0 for exactly SETTLE_CYCLES cycles.
REQ-021 CAPTURE: SHALL register BF_COUNT into RES_DATA and current index into RES_IDX, assert RES_VALID next cycle, go WAIT_RD.
REQ-022 WAIT_RD: RES_VALID, RES_DATA, RES_IDX SHALL hold stable until RES_READY=1; on handshake RES_VALID drops next cycle.
REQ-023 After handshake: if index+1 < effective NUM_MEAS, increment index and go STRESS (no new LOAD); else go FINISH.
REQ-024 FINISH: DONE=1 one cycle, SEL_INV*/AC_DC cleared, return IDLE; CFG_READY=1 the following cycle.
REQ-025 CFG_VALID while BUSY SHALL be ignored (CFG_READY=0).
REQ-026 START and MEAS_TRIG SHALL never be high in the same cycle; at least one cycle of both low between STRESS and MEAS is not required.
REQ-027 Duration counters SHALL be 16 bits, compare terminal value count==N-1, no wrap-around beyond terminal.
REQ-028 All outputs SHALL be registered (no combinational input-to-output path).

Reset
REQ-029 RESETB=0 at a CLK edge SHALL force IDLE from any state, including mid-STRESS/MEAS.
REQ-030 Reset values: all odometer controls 0, RES_VALID=0, RES_DATA=0, RES_IDX=0, BUSY=0, DONE=0, CFG_READY=0 during reset, 1 the first cycle after.

Configuration
REQ-031 Macro ODO_CTRL_MINMAX_EN defined: SHALL add outputs MIN_COUNT[11:0], MAX_COUNT[11:0], updated at each CAPTURE, initialised to 12'hFFF/12'h000 at campaign accept and reset.
REQ-032 Macro undefined: MIN_COUNT/MAX_COUNT ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 CFG_SEL=10, AC_DC=1, STRESS=10, NUM=1, MEAS_CYCLES=256 -> LOAD 1 cycle, SEL_INV101=1, START high 10 cycles, MEAS_TRIG high 256 cycles, RES_VALID after 4 settle+1 capture cycles, DONE pulse.
REQ-034 NUM_MEAS=3, BF_COUNT driven 100,200,150 -> RES_IDX 0,1,2 with matching RES_DATA, single LOAD pulse; MINMAX_EN -> MIN=100, MAX=200.
REQ-035 RES_READY held low 20 cycles -> RES_VALID/RES_DATA stable 20 cycles, no next STRESS started.
REQ-036 CFG_STRESS_CYCLES=0, NUM_MEAS=0 -> START never asserted, exactly one result, DONE.
REQ-037 RESETB low mid-MEAS -> next cycle MEAS_TRIG=0, BUSY=0, RES_VALID=0, IDLE; new CFG accepted after release.
REQ-038 CFG_VALID pulsed while BUSY -> ignored, campaign unchanged.

Source files
------------

// File: rtl/odometer_meas_ctrl.sv
// odometer_meas_ctrl: sequences odometer load/stress/measure campaigns; define ODO_CTRL_MINMAX_EN for MIN_COUNT/MAX_COUNT tracking
module odometer_meas_ctrl #(
  parameter int MEAS_CYCLES   = 256,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [1:0]  CFG_SEL,
  input  logic        CFG_AC_DC,
  input  logic [15:0] CFG_STRESS_CYCLES,
  input  logic [3:0]  CFG_NUM_MEAS,
  output logic        LOAD,
  output logic        SEL_INV97,
  output logic        SEL_INV99,
  output logic        SEL_INV101,
  output logic        START,
  output logic        AC_DC,
  output logic        MEAS_TRIG,
  input  logic [11:0] BF_COUNT,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [11:0] RES_DATA,
  output logic [3:0]  RES_IDX,
  output logic        BUSY,
`ifdef ODO_CTRL_MINMAX_EN
  output logic [11:0] MIN_COUNT,
  output logic [11:0] MAX_COUNT,
`endif
  output logic        DONE
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STRESS, S_MEAS, S_SETTLE, S_CAPTURE, S_WAIT_RD, S_FINISH} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, stress_q, stress_d;
  logic [3:0] idx_q, idx_d, num_q, num_d, res_idx_q, res_idx_d;
  logic [2:0] sel_q, sel_d;
  logic [11:0] res_data_q, res_data_d, min_q, min_d, max_q, max_d;
  logic ac_dc_q, ac_dc_d, load_q, load_d, start_q, start_d, trig_q, trig_d;
  logic rdy_q, rdy_d, busy_q, busy_d, done_q, done_d, res_valid_q, res_valid_d;
  // next-state, counters and registered output values derived from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stress_d = stress_q;
    num_d = num_q;
    idx_d = idx_q;
    sel_d = sel_q;
    ac_dc_d = ac_dc_q;
    res_data_d = res_data_q;
    res_idx_d = res_idx_q;
    min_d = min_q;
    max_d = max_q;
    case (state_q)
      S_IDLE: if (CFG_VALID && rdy_q) begin
        state_d = S_LOAD;
        stress_d = CFG_STRESS_CYCLES;
        num_d = CFG_NUM_MEAS == 4'd0 ? 4'd1 : CFG_NUM_MEAS;
        idx_d = 4'd0;
        sel_d = CFG_SEL == 2'd0 ? 3'b001 : CFG_SEL == 2'd2 ? 3'b100 : 3'b010;
        ac_dc_d = CFG_AC_DC;
        min_d = 12'hFFF;
        max_d = 12'h000;
      end
      S_LOAD: begin
        state_d = stress_q == 16'd0 ? S_MEAS : S_STRESS;
        cnt_d = 16'd0;
      end
      S_STRESS: begin
        state_d = cnt_q == stress_q - 16'd1 ? S_MEAS : S_STRESS;
        cnt_d = cnt_q == stress_q - 16'd1 ? 16'd0 : cnt_q + 16'd1;
      end
      S_MEAS: begin
        state_d = cnt_q == 16'(MEAS_CYCLES - 1) ? S_SETTLE : S_MEAS;
        cnt_d = cnt_q == 16'(MEAS_CYCLES - 1) ? 16'd0 : cnt_q + 16'd1;
      end
      S_SETTLE: begin
        state_d = cnt_q == 16'(SETTLE_CYCLES - 1) ? S_CAPTURE : S_SETTLE;
        cnt_d = cnt_q == 16'(SETTLE_CYCLES - 1) ? 16'd0 : cnt_q + 16'd1;
      end
      S_CAPTURE: begin
        state_d = S_WAIT_RD;
        res_data_d = BF_COUNT;
        res_idx_d = idx_q;
        min_d = BF_COUNT < min_q ? BF_COUNT : min_q;
        max_d = BF_COUNT > max_q ? BF_COUNT : max_q;
      end
      S_WAIT_RD: if (RES_READY && res_valid_q) begin
        state_d = idx_q + 4'd1 < num_q ? (stress_q == 16'd0 ? S_MEAS : S_STRESS) : S_FINISH;
        idx_d = idx_q + 4'd1 < num_q ? idx_q + 4'd1 : idx_q;
        cnt_d = 16'd0;
      end
      default: state_d = S_IDLE;
    endcase
    sel_d = state_d == S_IDLE || state_d == S_FINISH ? 3'b000 : sel_d;
    ac_dc_d = state_d == S_IDLE || state_d == S_FINISH ? 1'b0 : ac_dc_d;
    load_d = state_d == S_LOAD;
    start_d = state_d == S_STRESS;
    trig_d = state_d == S_MEAS;
    res_valid_d = state_d == S_WAIT_RD;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_FINISH;
    rdy_d = state_d == S_IDLE;
  end
  // state and all outputs registered; synchronous active-low reset returns to IDLE
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      stress_q <= '0;
      num_q <= '0;
      idx_q <= '0;
      sel_q <= '0;
      ac_dc_q <= 1'b0;
      res_data_q <= '0;
      res_idx_q <= '0;
      min_q <= 12'hFFF;
      max_q <= 12'h000;
      load_q <= 1'b0;
      start_q <= 1'b0;
      trig_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stress_q <= stress_d;
      num_q <= num_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      ac_dc_q <= ac_dc_d;
      res_data_q <= res_data_d;
      res_idx_q <= res_idx_d;
      min_q <= min_d;
      max_q <= max_d;
      load_q <= load_d;
      start_q <= start_d;
      trig_q <= trig_d;
      res_valid_q <= res_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rdy_q <= rdy_d;
    end
  end
  assign CFG_READY = rdy_q;
  assign LOAD = load_q;
  assign {SEL_INV101, SEL_INV99, SEL_INV97} = sel_q;
  assign START = start_q;
  assign AC_DC = ac_dc_q;
  assign MEAS_TRIG = trig_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA = res_data_q;
  assign RES_IDX = res_idx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef ODO_CTRL_MINMAX_EN
  assign MIN_COUNT = min_q;
  assign MAX_COUNT = max_q;
`endif
endmodule

// File: tb/tb_odometer_meas_ctrl.sv
// tb_odometer_meas_ctrl: table-driven campaign checks plus reset and handshake corner sequences
module tb_odometer_meas_ctrl;
  logic CLK = 1'b0;
  logic RESETB, CFG_VALID, CFG_READY, CFG_AC_DC, RES_VALID, RES_READY, BUSY, DONE;
  logic [1:0] CFG_SEL;
  logic [15:0] CFG_STRESS_CYCLES;
  logic [3:0] CFG_NUM_MEAS, RES_IDX;
  logic LOAD, SEL_INV97, SEL_INV99, SEL_INV101, START, AC_DC, MEAS_TRIG;
  logic [11:0] BF_COUNT, RES_DATA;
`ifdef ODO_CTRL_MINMAX_EN
  logic [11:0] MIN_COUNT, MAX_COUNT;
`endif
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  odometer_meas_ctrl dut (
    .CLK(CLK), .RESETB(RESETB), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_SEL(CFG_SEL), .CFG_AC_DC(CFG_AC_DC), .CFG_STRESS_CYCLES(CFG_STRESS_CYCLES),
    .CFG_NUM_MEAS(CFG_NUM_MEAS), .LOAD(LOAD), .SEL_INV97(SEL_INV97), .SEL_INV99(SEL_INV99),
    .SEL_INV101(SEL_INV101), .START(START), .AC_DC(AC_DC), .MEAS_TRIG(MEAS_TRIG),
    .BF_COUNT(BF_COUNT), .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_IDX(RES_IDX), .BUSY(BUSY),
`ifdef ODO_CTRL_MINMAX_EN
    .MIN_COUNT(MIN_COUNT), .MAX_COUNT(MAX_COUNT),
`endif
    .DONE(DONE));
  typedef struct {
    logic [1:0] sel;
    logic acdc;
    logic [15:0] stress;
    logic [3:0] num;
    int hold;
    bit poke;
    logic [3:0][11:0] bf;
    logic [2:0] e_sel;
    int e_start;
    int e_meas;
    int e_nres;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic send_cfg(input logic [1:0] sel, input logic acdc, input logic [15:0] stress, input logic [3:0] num);
    int n = 0;
    @(negedge CLK);
    CFG_SEL = sel;
    CFG_AC_DC = acdc;
    CFG_STRESS_CYCLES = stress;
    CFG_NUM_MEAS = num;
    CFG_VALID = 1'b1;
    while (!CFG_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("cfg_ready_wait", int'(CFG_READY), 1);
    @(negedge CLK);
    CFG_VALID = 1'b0;
  endtask
  task automatic run_campaign(input int k);
    vec_t v = tbl[k];
    int loads = 0, starts = 0, meas = 0, dones = 0, nres = 0, overlap = 0, sel_err = 0;
    int acdc_err = 0, rdy_err = 0, hold_err = 0, vcyc = 0, last_meas = 0, hold_left = v.hold;
    bit fin = 0, prev_valid = 0, poked = 0;
    logic [15:0] held = '0;
    BF_COUNT = v.bf[0];
    send_cfg(v.sel, v.acdc, v.stress, v.num);
    for (int c = 0; c < 6000 && !fin; c++) begin
      if (dones > 0) begin
        chk("cfg_ready_after_done", int'(CFG_READY), 1);
        chk("done_one_cycle", int'(DONE), 0);
        chk("busy_after_done", int'(BUSY), 0);
        fin = 1;
      end else begin
        loads += int'(LOAD);
        starts += int'(START);
        meas += int'(MEAS_TRIG);
        dones += int'(DONE);
        if (START && MEAS_TRIG) overlap++;
        if (LOAD || START || MEAS_TRIG || RES_VALID) begin
          if ({SEL_INV101, SEL_INV99, SEL_INV97} !== v.e_sel) sel_err++;
          if (AC_DC !== v.acdc) acdc_err++;
        end
        if (CFG_READY) rdy_err++;
        if (MEAS_TRIG) last_meas = c;
        CFG_VALID = 1'b0;
        if (MEAS_TRIG && v.poke && !poked) begin
          poked = 1;
          CFG_VALID = 1'b1;
          CFG_SEL = 2'd0;
          CFG_STRESS_CYCLES = 16'd7;
          CFG_NUM_MEAS = 4'd9;
        end
        RES_READY = 1'b0;
        if (RES_VALID) begin
          vcyc++;
          if (!prev_valid) begin
            chk($sformatf("res_data_%0d_%0d", k, nres), int'(RES_DATA), nres < 4 ? int'(v.bf[nres]) : 0);
            chk($sformatf("res_idx_%0d_%0d", k, nres), int'(RES_IDX), nres);
            chk($sformatf("settle_gap_%0d_%0d", k, nres), c - last_meas, 6);
            held = {RES_IDX, RES_DATA};
          end else if ({RES_IDX, RES_DATA} !== held || START || MEAS_TRIG) hold_err++;
          if (hold_left > 0) hold_left--;
          else begin
            RES_READY = 1'b1;
            nres++;
          end
        end
        prev_valid = RES_VALID;
        BF_COUNT = nres < 4 ? v.bf[nres] : 12'd0;
      end
      @(negedge CLK);
    end
    RES_READY = 1'b0;
    chk($sformatf("campaign_end_%0d", k), int'(fin), 1);
    chk($sformatf("load_pulses_%0d", k), loads, 1);
    chk($sformatf("start_cycles_%0d", k), starts, v.e_start);
    chk($sformatf("meas_cycles_%0d", k), meas, v.e_meas);
    chk($sformatf("done_pulses_%0d", k), dones, 1);
    chk($sformatf("results_%0d", k), nres, v.e_nres);
    chk($sformatf("valid_cycles_%0d", k), vcyc, v.hold + v.e_nres);
    chk($sformatf("start_meas_overlap_%0d", k), overlap, 0);
    chk($sformatf("sel_errors_%0d", k), sel_err, 0);
    chk($sformatf("acdc_errors_%0d", k), acdc_err, 0);
    chk($sformatf("cfg_ready_busy_%0d", k), rdy_err, 0);
    chk($sformatf("hold_errors_%0d", k), hold_err, 0);
  endtask
  initial begin
    tbl[0] = '{2'd2, 1'b1, 16'd10, 4'd1, 0, 1'b0, {12'd0, 12'd0, 12'd0, 12'd321}, 3'b100, 10, 256, 1};
    tbl[1] = '{2'd1, 1'b0, 16'd3, 4'd3, 0, 1'b0, {12'd0, 12'd150, 12'd200, 12'd100}, 3'b010, 9, 768, 3};
    tbl[2] = '{2'd0, 1'b0, 16'd0, 4'd0, 0, 1'b0, {12'd0, 12'd0, 12'd0, 12'd55}, 3'b001, 0, 256, 1};
    tbl[3] = '{2'd3, 1'b1, 16'd1, 4'd2, 0, 1'b1, {12'd0, 12'd0, 12'd0, 12'd4095}, 3'b010, 2, 512, 2};
    tbl[4] = '{2'd0, 1'b1, 16'd2, 4'd2, 20, 1'b0, {12'd0, 12'd0, 12'd66, 12'd77}, 3'b001, 4, 512, 2};
    RESETB = 1'b0;
    CFG_VALID = 1'b0;
    CFG_SEL = '0;
    CFG_AC_DC = 1'b0;
    CFG_STRESS_CYCLES = '0;
    CFG_NUM_MEAS = '0;
    RES_READY = 1'b0;
    BF_COUNT = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", int'({CFG_READY, LOAD, SEL_INV97, SEL_INV99, SEL_INV101, START, AC_DC, MEAS_TRIG, RES_VALID, BUSY, DONE}), 0);
    chk("reset_res_data", int'(RES_DATA), 0);
    chk("reset_res_idx", int'(RES_IDX), 0);
    RESETB = 1'b1;
    @(negedge CLK);
    chk("cfg_ready_after_reset", int'(CFG_READY), 1);
    chk("busy_after_reset", int'(BUSY), 0);
    for (int k = 0; k < 5; k++) begin
      run_campaign(k);
`ifdef ODO_CTRL_MINMAX_EN
      if (k == 1) begin
        chk("min_count", int'(MIN_COUNT), 100);
        chk("max_count", int'(MAX_COUNT), 200);
      end
`endif
    end
    begin
      int n = 0;
      send_cfg(2'd1, 1'b1, 16'd2, 4'd1);
      while (!MEAS_TRIG && n < 100) begin
        @(negedge CLK);
        n++;
      end
      chk("meas_reached", int'(MEAS_TRIG), 1);
      repeat (10) @(negedge CLK);
      RESETB = 1'b0;
      @(negedge CLK);
      chk("rst_mid_meas_trig", int'(MEAS_TRIG), 0);
      chk("rst_mid_meas_busy", int'(BUSY), 0);
      chk("rst_mid_meas_valid", int'(RES_VALID), 0);
      chk("rst_mid_meas_ready", int'(CFG_READY), 0);
      chk("rst_mid_meas_ctrl", int'({SEL_INV97, SEL_INV99, SEL_INV101, AC_DC, START, LOAD}), 0);
      RESETB = 1'b1;
      @(negedge CLK);
      chk("rst_release_ready", int'(CFG_READY), 1);
      run_campaign(2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
